axi_bridge_burst: RTL and testbench

Parametrised AXI3 master bridge between the CPU's instruction/data cache ports and the AXI interconnect. It replaces the single-beat bridge. Additions over that bridge:
- cache-line burst reads and writes (uncached single-word access still supported);
- a beat counter;
- a line-sized write buffer;
- a read-after-write address hazard check.

It sits between the icache/dcache and the top-level AXI port of mycpu.

---
 rtl/axi_bridge_burst.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_axi_bridge_burst.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_bridge_burst.sv
// AXI3 master bridge for the instruction/data caches: line bursts or single words,
// with a line-sized write buffer and a read-after-write line hazard check.
`timescale 1ns/1ps
module axi_bridge_burst #(
  parameter int         ADDR_W     = 32,
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] RID_INST   = 4'd0,
  parameter logic [3:0] RID_DATA   = 4'd1
) (
  input  logic                     clk,
  input  logic                     areset,
  // instruction read port
  input  logic                     i_rd_req,
  input  logic                     i_rd_type,
  input  logic [2:0]               i_rd_size,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  output logic                     i_rd_rdy,
  output logic                     i_ret_valid,
  output logic                     i_ret_last,
  output logic [31:0]              i_ret_data,
  // data read port
  input  logic                     d_rd_req,
  input  logic                     d_rd_type,
  input  logic [2:0]               d_rd_size,
  input  logic [ADDR_W-1:0]        d_rd_addr,
  output logic                     d_rd_rdy,
  output logic                     d_ret_valid,
  output logic                     d_ret_last,
  output logic [31:0]              d_ret_data,
  // data write port
  input  logic                     wr_req,
  input  logic                     wr_type,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [2:0]               wr_size,
  input  logic [3:0]               wr_wstrb,
  input  logic [32*LINE_WORDS-1:0] wr_data,
  output logic                     wr_rdy,
  output logic                     wr_done,
  // AXI read address
  output logic [3:0]               arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [3:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic [1:0]               arlock,
  output logic [3:0]               arcache,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  // AXI read data
  input  logic [3:0]               rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  // AXI write address
  output logic [3:0]               awid,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [3:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic [1:0]               awlock,
  output logic [3:0]               awcache,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  // AXI write data
  output logic [3:0]               wid,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  // AXI write response
  input  logic [3:0]               bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int         OFF_W     = $clog2(LINE_WORDS) + 2;
  localparam int         BEAT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [3:0] LINE_LEN  = 4'(LINE_WORDS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

  r_state_e              r_state_q, r_state_d;
  logic                  r_port_q, r_port_d;      // 1 = data port
  logic                  r_type_q, r_type_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [ADDR_W-1:0]     r_addr_q, r_addr_d;
  logic [BEAT_W-1:0]     r_beat_q, r_beat_d;

  w_state_e              w_state_q, w_state_d;
  logic                  w_type_q, w_type_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic [ADDR_W-1:0]     w_addr_q, w_addr_d;
  logic [LINE_WORDS-1:0][31:0] w_buf_q, w_buf_d;
  logic [BEAT_W-1:0]     w_beat_q, w_beat_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_sent_q, w_sent_d;

  logic                  wr_accept, hazard_d, hazard_i, beat_hit, aw_fin, w_fin;

  // Write buffer is free only when idle and out of reset; a write accepted this
  // very cycle also counts against a read to the same line.
  assign wr_rdy    = (w_state_q == W_IDLE) & ~areset;
  assign wr_accept = wr_req & wr_rdy;
  assign hazard_d  = ((w_state_q != W_IDLE) & (d_rd_addr[ADDR_W-1:OFF_W] == w_addr_q[ADDR_W-1:OFF_W]))
                   | (wr_accept & (d_rd_addr[ADDR_W-1:OFF_W] == wr_addr[ADDR_W-1:OFF_W]));
  assign hazard_i  = ((w_state_q != W_IDLE) & (i_rd_addr[ADDR_W-1:OFF_W] == w_addr_q[ADDR_W-1:OFF_W]))
                   | (wr_accept & (i_rd_addr[ADDR_W-1:OFF_W] == wr_addr[ADDR_W-1:OFF_W]));

  assign arid    = r_port_q ? RID_DATA : RID_INST;
  assign araddr  = r_addr_q;
  assign arlen   = r_type_q ? LINE_LEN : 4'd0;
  assign arsize  = r_size_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awid    = RID_DATA;
  assign wid     = RID_DATA;
  assign awaddr  = w_addr_q;
  assign awlen   = w_type_q ? LINE_LEN : 4'd0;
  assign awsize  = w_size_q;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wdata   = w_buf_q[w_beat_q];
  assign wstrb   = w_strb_q;

  assign beat_hit   = rvalid & (rid == arid);
  assign i_ret_data = rdata;
  assign d_ret_data = rdata;

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    r_state_d   = r_state_q;
    r_port_d    = r_port_q;
    r_type_d    = r_type_q;
    r_size_d    = r_size_q;
    r_addr_d    = r_addr_q;
    r_beat_d    = r_beat_q;
    d_rd_rdy    = 1'b0;
    i_rd_rdy    = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    d_ret_valid = 1'b0;
    i_ret_valid = 1'b0;
    d_ret_last  = 1'b0;
    i_ret_last  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        d_rd_rdy = ~areset & ~hazard_d;
        i_rd_rdy = ~areset & ~d_rd_req & ~hazard_i;
        if (d_rd_req && d_rd_rdy) begin
          r_port_d  = 1'b1;
          r_type_d  = d_rd_type;
          r_size_d  = d_rd_type ? 3'd2 : d_rd_size;
          r_addr_d  = d_rd_addr;
          r_beat_d  = '0;
          r_state_d = R_AR;
        end else if (i_rd_req && i_rd_rdy) begin
          r_port_d  = 1'b0;
          r_type_d  = i_rd_type;
          r_size_d  = i_rd_type ? 3'd2 : i_rd_size;
          r_addr_d  = i_rd_addr;
          r_beat_d  = '0;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (beat_hit) begin
          d_ret_valid = r_port_q;
          i_ret_valid = ~r_port_q;
          d_ret_last  = r_port_q & rlast;
          i_ret_last  = ~r_port_q & rlast;
          r_beat_d    = r_beat_q + 1'b1;
          if (rlast) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    w_type_d  = w_type_q;
    w_size_d  = w_size_q;
    w_strb_d  = w_strb_q;
    w_addr_d  = w_addr_q;
    w_buf_d   = w_buf_q;
    w_beat_d  = w_beat_q;
    aw_done_d = aw_done_q;
    w_sent_d  = w_sent_q;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    wr_done   = 1'b0;
    aw_fin    = 1'b0;
    w_fin     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (wr_accept) begin
          w_type_d  = wr_type;
          w_size_d  = wr_type ? 3'd2 : wr_size;
          w_strb_d  = wr_type ? 4'hf : wr_wstrb;
          w_addr_d  = wr_addr;
          w_buf_d   = wr_data;
          w_beat_d  = '0;
          aw_done_d = 1'b0;
          w_sent_d  = 1'b0;
          w_state_d = W_SEND;
        end
      end
      W_SEND: begin
        awvalid = ~aw_done_q;
        wvalid  = ~w_sent_q;
        wlast   = wvalid & (w_beat_q == (w_type_q ? LAST_BEAT : '0));
        aw_fin  = aw_done_q | (awvalid & awready);
        w_fin   = w_sent_q | (wvalid & wready & wlast);
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready) begin
          if (wlast) w_sent_d = 1'b1;
          else       w_beat_d = w_beat_q + 1'b1;
        end
        // Address and data channels finish independently, possibly together.
        if (aw_fin && w_fin) w_state_d = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          wr_done   = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the write buffer is
  // reset too, so it reads as zero after any abandoned burst.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      r_port_q  <= 1'b0;
      r_type_q  <= 1'b0;
      r_size_q  <= 3'd0;
      r_addr_q  <= '0;
      r_beat_q  <= '0;
      w_state_q <= W_IDLE;
      w_type_q  <= 1'b0;
      w_size_q  <= 3'd0;
      w_strb_q  <= 4'd0;
      w_addr_q  <= '0;
      w_buf_q   <= '0;
      w_beat_q  <= '0;
      aw_done_q <= 1'b0;
      w_sent_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_port_q  <= r_port_d;
      r_type_q  <= r_type_d;
      r_size_q  <= r_size_d;
      r_addr_q  <= r_addr_d;
      r_beat_q  <= r_beat_d;
      w_state_q <= w_state_d;
      w_type_q  <= w_type_d;
      w_size_q  <= w_size_d;
      w_strb_q  <= w_strb_d;
      w_addr_q  <= w_addr_d;
      w_buf_q   <= w_buf_d;
      w_beat_q  <= w_beat_d;
      aw_done_q <= aw_done_d;
      w_sent_q  <= w_sent_d;
    end
  end

endmodule

// File: tb/tb_axi_bridge_burst.sv
// Directed bench for axi_bridge_burst: word/line reads, arbitration, buffered line
// write, line hazard and reset in the middle of a burst.
`timescale 1ns/1ps
module tb_axi_bridge_burst;
  localparam int ADDR_W     = 32;
  localparam int LINE_WORDS = 4;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic i_rd_req, i_rd_type, i_rd_rdy, i_ret_valid, i_ret_last;
  logic [2:0] i_rd_size;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [31:0] i_ret_data;
  logic d_rd_req, d_rd_type, d_rd_rdy, d_ret_valid, d_ret_last;
  logic [2:0] d_rd_size;
  logic [ADDR_W-1:0] d_rd_addr;
  logic [31:0] d_ret_data;
  logic wr_req, wr_type, wr_rdy, wr_done;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0] wr_size;
  logic [3:0] wr_wstrb;
  logic [32*LINE_WORDS-1:0] wr_data;
  logic [3:0] arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [2:0] arsize, arprot, awsize, awprot;
  logic [1:0] arburst, arlock, rresp, awburst, awlock, bresp;
  logic arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [31:0] rdata, wdata;
  logic wlast, wvalid, wready, bvalid, bready;

  axi_bridge_burst #(.ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .RID_INST(4'd0), .RID_DATA(4'd1)) dut (
    .clk(clk), .areset(areset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_size(i_rd_size), .i_rd_addr(i_rd_addr),
    .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_size(d_rd_size), .d_rd_addr(d_rd_addr),
    .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_size(wr_size), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the AR request, check its fields, then accept it.
  task automatic ar_accept(input string tag, input logic [3:0] id, input logic [3:0] len,
                           input logic [31:0] addr);
    for (int i = 0; i < 8 && !arvalid; i++) tick();
    check({tag, "_arvalid"}, 64'(arvalid), 64'd1);
    check({tag, "_arid"},    64'(arid),    64'(id));
    check({tag, "_arlen"},   64'(arlen),   64'(len));
    check({tag, "_arsize"},  64'(arsize),  64'd2);
    check({tag, "_araddr"},  64'(araddr),  64'(addr));
    check({tag, "_arburst"}, 64'(arburst), 64'd1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  // Present one R beat and check it lands on the expected port only.
  task automatic r_beat(input string tag, input logic [3:0] id, input logic [31:0] data,
                        input logic last, input logic to_d);
    rvalid = 1'b1; rid = id; rdata = data; rlast = last;
    #1;
    check({tag, "_rready"}, 64'(rready), 64'd1);
    if (to_d) begin
      check({tag, "_dvalid"}, 64'(d_ret_valid), 64'd1);
      check({tag, "_ddata"},  64'(d_ret_data),  64'(data));
      check({tag, "_dlast"},  64'(d_ret_last),  64'(last));
      check({tag, "_ivalid"}, 64'(i_ret_valid), 64'd0);
    end else begin
      check({tag, "_ivalid"}, 64'(i_ret_valid), 64'd1);
      check({tag, "_idata"},  64'(i_ret_data),  64'(data));
      check({tag, "_ilast"},  64'(i_ret_last),  64'(last));
      check({tag, "_dvalid"}, 64'(d_ret_valid), 64'd0);
    end
    tick();
    rvalid = 1'b0; rlast = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    i_rd_req = 0; i_rd_type = 0; i_rd_size = 3'd2; i_rd_addr = '0;
    d_rd_req = 0; d_rd_type = 0; d_rd_size = 3'd2; d_rd_addr = '0;
    wr_req = 0; wr_type = 0; wr_addr = '0; wr_size = 3'd2; wr_wstrb = 4'h0; wr_data = '0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_d_rdy", 64'(d_rd_rdy), 64'd0);
    check("rst_i_rdy", 64'(i_rd_rdy), 64'd0);
    check("rst_wr_rdy", 64'(wr_rdy), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    areset = 1'b0;
    #1;
    check("idle_d_rdy", 64'(d_rd_rdy), 64'd1);
    check("idle_i_rdy", 64'(i_rd_rdy), 64'd1);
    check("idle_wr_rdy", 64'(wr_rdy), 64'd1);

    // 1: uncached word read on the data port
    d_rd_req = 1; d_rd_type = 0; d_rd_size = 3'd2; d_rd_addr = 32'h1c00_0100;
    #1;
    check("t1_d_rdy", 64'(d_rd_rdy), 64'd1);
    tick();
    d_rd_req = 0;
    check("t1_busy_d_rdy", 64'(d_rd_rdy), 64'd0);
    ar_accept("t1", 4'd1, 4'd0, 32'h1c00_0100);
    r_beat("t1_b0", 4'd1, 32'hdead_beef, 1'b1, 1'b1);
    #1;
    check("t1_d_rdy_after", 64'(d_rd_rdy), 64'd1);

    // 2: line read on the instruction port with gaps between beats
    i_rd_req = 1; i_rd_type = 1; i_rd_addr = 32'h1c00_0040;
    #1;
    check("t2_i_rdy", 64'(i_rd_rdy), 64'd1);
    tick();
    i_rd_req = 0;
    ar_accept("t2", 4'd0, 4'd3, 32'h1c00_0040);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_gap_ivalid", 64'(i_ret_valid), 64'd0);
      tick();
      r_beat("t2_beat", 4'd0, 32'(k), 1'(k == 3), 1'b0);
    end

    // 3: simultaneous requests, data port first, then instruction port
    d_rd_req = 1; d_rd_type = 0; d_rd_addr = 32'h1c00_0200;
    i_rd_req = 1; i_rd_type = 0; i_rd_addr = 32'h1c00_0300;
    #1;
    check("t3_d_rdy", 64'(d_rd_rdy), 64'd1);
    check("t3_i_rdy_lose", 64'(i_rd_rdy), 64'd0);
    tick();
    d_rd_req = 0;
    #1;
    check("t3_i_rdy_busy", 64'(i_rd_rdy), 64'd0);
    ar_accept("t3d", 4'd1, 4'd0, 32'h1c00_0200);
    r_beat("t3d_b0", 4'd1, 32'h0000_0200, 1'b1, 1'b1);
    #1;
    check("t3_i_rdy_after", 64'(i_rd_rdy), 64'd1);
    tick();
    i_rd_req = 0;
    ar_accept("t3i", 4'd0, 4'd0, 32'h1c00_0300);
    r_beat("t3i_b0", 4'd0, 32'h0000_0300, 1'b1, 1'b0);

    // 4: line write with awready delayed past the W beats
    wr_req = 1; wr_type = 1; wr_addr = 32'h1c00_0400; wr_wstrb = 4'h3;
    wr_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    #1;
    check("t4_wr_rdy", 64'(wr_rdy), 64'd1);
    tick();
    wr_req = 0; wready = 1;
    check("t4_awlen", 64'(awlen), 64'd3);
    check("t4_awaddr", 64'(awaddr), 64'h1c00_0400);
    check("t4_awsize", 64'(awsize), 64'd2);
    check("t4_wr_rdy_busy", 64'(wr_rdy), 64'd0);
    for (int k = 0; k < 4; k++) begin
      check("t4_wvalid", 64'(wvalid), 64'd1);
      check("t4_awvalid", 64'(awvalid), 64'd1);
      check("t4_wdata", 64'(wdata), 64'(32'hA0 + k));
      check("t4_wstrb", 64'(wstrb), 64'hf);
      check("t4_wlast", 64'(wlast), 64'(k == 3));
      tick();
    end
    wready = 0;
    check("t4_wvalid_done", 64'(wvalid), 64'd0);
    for (int k = 0; k < 5; k++) begin
      check("t4_bready_wait", 64'(bready), 64'd0);
      check("t4_awvalid_hold", 64'(awvalid), 64'd1);
      tick();
    end
    awready = 1;
    tick();
    awready = 0;
    check("t4_awvalid_off", 64'(awvalid), 64'd0);
    check("t4_bready", 64'(bready), 64'd1);
    check("t4_no_done", 64'(wr_done), 64'd0);
    bvalid = 1;
    #1;
    check("t4_wr_done", 64'(wr_done), 64'd1);
    tick();
    bvalid = 0;
    #1;
    check("t4_done_pulse", 64'(wr_done), 64'd0);
    check("t4_wr_rdy_after", 64'(wr_rdy), 64'd1);

    // 5: read-after-write line hazard
    wr_req = 1; wr_type = 1; wr_addr = 32'h1c00_0080;
    wr_data = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    d_rd_req = 1; d_rd_type = 0; d_rd_addr = 32'h1c00_0084;
    #1;
    check("t5_wr_rdy", 64'(wr_rdy), 64'd1);
    check("t5_haz_incoming", 64'(d_rd_rdy), 64'd0);
    tick();
    wr_req = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_haz_pending", 64'(d_rd_rdy), 64'd0);
      tick();
    end
    d_rd_addr = 32'h1c00_0100;
    #1;
    check("t5_other_line_rdy", 64'(d_rd_rdy), 64'd1);
    tick();
    d_rd_req = 0;
    ar_accept("t5a", 4'd1, 4'd0, 32'h1c00_0100);
    r_beat("t5a_b0", 4'd1, 32'h55aa_55aa, 1'b1, 1'b1);
    d_rd_req = 1; d_rd_addr = 32'h1c00_0084;
    #1;
    check("t5_haz_again", 64'(d_rd_rdy), 64'd0);
    awready = 1; wready = 1;
    tick();
    awready = 0;
    repeat (3) tick();
    wready = 0;
    check("t5_bready", 64'(bready), 64'd1);
    check("t5_haz_resp", 64'(d_rd_rdy), 64'd0);
    bvalid = 1;
    #1;
    check("t5_wr_done", 64'(wr_done), 64'd1);
    check("t5_haz_done_cycle", 64'(d_rd_rdy), 64'd0);
    tick();
    bvalid = 0;
    #1;
    check("t5_rdy_after_done", 64'(d_rd_rdy), 64'd1);
    tick();
    d_rd_req = 0;
    ar_accept("t5b", 4'd1, 4'd0, 32'h1c00_0084);
    r_beat("t5b_b0", 4'd1, 32'h0000_0084, 1'b1, 1'b1);

    // 6: reset during beat 2 of a line read, with a single-word write also pending
    d_rd_req = 1; d_rd_type = 1; d_rd_addr = 32'h1c00_0500;
    wr_req = 1; wr_type = 0; wr_addr = 32'h1c00_0600; wr_wstrb = 4'h3;
    wr_data = {32'h0, 32'h0, 32'h0, 32'hC0};
    #1;
    check("t6_d_rdy", 64'(d_rd_rdy), 64'd1);
    check("t6_wr_rdy", 64'(wr_rdy), 64'd1);
    tick();
    d_rd_req = 0; wr_req = 0;
    check("t6_awvalid_live", 64'(awvalid), 64'd1);
    check("t6_wstrb_word", 64'(wstrb), 64'h3);
    check("t6_wlast_word", 64'(wlast), 64'd1);
    check("t6_awlen_word", 64'(awlen), 64'd0);
    ar_accept("t6", 4'd1, 4'd3, 32'h1c00_0500);
    r_beat("t6_b0", 4'd1, 32'h10, 1'b0, 1'b1);
    r_beat("t6_b1", 4'd1, 32'h11, 1'b0, 1'b1);
    rvalid = 1; rid = 4'd1; rdata = 32'h12; rlast = 0;
    areset = 1;
    #1;
    check("t6_rready", 64'(rready), 64'd0);
    check("t6_arvalid", 64'(arvalid), 64'd0);
    check("t6_awvalid", 64'(awvalid), 64'd0);
    check("t6_wvalid", 64'(wvalid), 64'd0);
    check("t6_bready", 64'(bready), 64'd0);
    check("t6_dvalid", 64'(d_ret_valid), 64'd0);
    check("t6_d_rdy_rst", 64'(d_rd_rdy), 64'd0);
    tick();
    rvalid = 0;
    areset = 0;
    #1;
    check("t6_d_rdy_rel", 64'(d_rd_rdy), 64'd1);
    check("t6_wr_rdy_rel", 64'(wr_rdy), 64'd1);
    check("t6_awvalid_rel", 64'(awvalid), 64'd0);
    d_rd_req = 1; d_rd_type = 0; d_rd_size = 3'd2; d_rd_addr = 32'h1c00_0700;
    tick();
    d_rd_req = 0;
    ar_accept("t6f", 4'd1, 4'd0, 32'h1c00_0700);
    r_beat("t6f_b0", 4'd1, 32'h1234_5678, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
